// File: rtl/dbd_pkg.sv
// Shared types and default geometry for the backlight-dimming block timing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a; the pixel stream is free-running and never stalls.
package dbd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_FRAME_START = 2'd1,
        ST_ACTIVE      = 2'd2,
        ST_FRAME_END   = 2'd3
    } dbd_state_e;

    // Default geometry: 1920x1080 frame, 8-pixel words, 24x12 block grid
    localparam int DBD_H_BLOCKS       = 24;
    localparam int DBD_WORDS_PER_HBLK = 10;
    localparam int DBD_V_BLOCKS       = 12;
    localparam int DBD_LINES_PER_VBLK = 90;

    // Bus widths
    localparam int DBD_PIX_W   = 192;
    localparam int DBD_HDUTY_W = 24;
    localparam int DBD_VADDR_W = 4;
    localparam int DBD_LCNT_W  = 7;

endpackage

// File: rtl/dbd_block_pos_counter.sv
// Nested word / horizontal-block / line / vertical-block position counters for one frame.
// Latency: counts update on the clock edge that samples the word or line end.
// Backpressure: none; words past the end of a line are absorbed by a saturating full flag.
module dbd_block_pos_counter
    import dbd_pkg::*;
#(
    parameter int H_BLOCKS       = DBD_H_BLOCKS,
    parameter int WORDS_PER_HBLK = DBD_WORDS_PER_HBLK,
    parameter int V_BLOCKS       = DBD_V_BLOCKS,
    parameter int LINES_PER_VBLK = DBD_LINES_PER_VBLK,
    localparam int HBLK_W        = (H_BLOCKS > 1) ? $clog2(H_BLOCKS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    input  logic                   word_i,
    input  logic                   line_end_i,
    output logic [HBLK_W-1:0]      hblk_o,
    output logic [DBD_LCNT_W-1:0]  line_o,
    output logic [DBD_VADDR_W-1:0] vblk_o,
    output logic                   line_full_o,
    output logic                   last_line_o,
    output logic                   last_vblk_o
);

    localparam int WORD_W = (WORDS_PER_HBLK > 1) ? $clog2(WORDS_PER_HBLK) : 1;

    logic [WORD_W-1:0]      word_q, word_d;
    logic [HBLK_W-1:0]      hblk_q, hblk_d;
    logic                   full_q, full_d;
    logic [DBD_LCNT_W-1:0]  line_q, line_d;
    logic [DBD_VADDR_W-1:0] vblk_q, vblk_d;

    // Next position: frame clear wins, then line end, then a word inside the line
    always_comb begin
        word_d = word_q;
        hblk_d = hblk_q;
        full_d = full_q;
        line_d = line_q;
        vblk_d = vblk_q;
        if (clr_i) begin
            word_d = '0;
            hblk_d = '0;
            full_d = 1'b0;
            line_d = '0;
            vblk_d = '0;
        end else if (line_end_i) begin
            word_d = '0;
            hblk_d = '0;
            full_d = 1'b0;
            if (line_q == DBD_LCNT_W'(LINES_PER_VBLK - 1)) begin
                line_d = '0;
                // After the last block of the frame the address returns to 0
                vblk_d = (vblk_q == DBD_VADDR_W'(V_BLOCKS - 1)) ? '0 : vblk_q + DBD_VADDR_W'(1);
            end else begin
                line_d = line_q + DBD_LCNT_W'(1);
            end
        end else if (word_i && !full_q) begin
            if (word_q == WORD_W'(WORDS_PER_HBLK - 1)) begin
                word_d = '0;
                if (hblk_q == HBLK_W'(H_BLOCKS - 1)) begin
                    full_d = 1'b1;
                end else begin
                    hblk_d = hblk_q + HBLK_W'(1);
                end
            end else begin
                word_d = word_q + WORD_W'(1);
            end
        end
    end

    // Position registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            hblk_q <= '0;
            full_q <= 1'b0;
            line_q <= '0;
            vblk_q <= '0;
        end else begin
            word_q <= word_d;
            hblk_q <= hblk_d;
            full_q <= full_d;
            line_q <= line_d;
            vblk_q <= vblk_d;
        end
    end

    assign hblk_o      = hblk_q;
    assign line_o      = line_q;
    assign vblk_o      = vblk_q;
    assign line_full_o = full_q;
    assign last_line_o = (line_q == DBD_LCNT_W'(LINES_PER_VBLK - 1));
    assign last_vblk_o = (vblk_q == DBD_VADDR_W'(V_BLOCKS - 1));

endmodule

// File: rtl/dbd_block_timing_ctrl.sv
// Turns raw VSYNC/DE frame timing into block select, block address and frame control pulses.
// Latency: 1 cycle; every output, including the pixel word, describes the word sampled at the previous edge.
// Backpressure: none; the input stream is never stalled, timing faults raise a sticky error instead.
module dbd_block_timing_ctrl
    import dbd_pkg::*;
#(
    parameter int H_BLOCKS       = DBD_H_BLOCKS,
    parameter int WORDS_PER_HBLK = DBD_WORDS_PER_HBLK,
    parameter int V_BLOCKS       = DBD_V_BLOCKS,
    parameter int LINES_PER_VBLK = DBD_LINES_PER_VBLK
) (
    input  logic                   iODCK,
    input  logic                   iRST_n,
    input  logic                   iVSYNC,
    input  logic                   iDE,
    input  logic [DBD_PIX_W-1:0]   iPixelData,
    output logic [H_BLOCKS-1:0]    oH_Duty,
    output logic [DBD_PIX_W-1:0]   oPixelData,
    output logic [DBD_VADDR_W-1:0] oV_Address,
    output logic                   oV_Duty,
    output logic                   oOU_en,
    output logic                   oALG_rst,
    output logic [DBD_LCNT_W-1:0]  oV_Block_Duty_Count,
    output logic                   oFrameErr
);

    localparam int HBLK_W = (H_BLOCKS > 1) ? $clog2(H_BLOCKS) : 1;

    dbd_state_e state_q, state_d;
    logic       vsync_q, de_q;

    logic [HBLK_W-1:0]      hblk;
    logic [DBD_LCNT_W-1:0]  line;
    logic [DBD_VADDR_W-1:0] vblk;
    logic                   line_full, last_line, last_vblk;

    logic [H_BLOCKS-1:0]    h_duty_q, h_duty_d;
    logic [DBD_PIX_W-1:0]   pix_q, pix_d;
    logic [DBD_VADDR_W-1:0] vaddr_q, vaddr_d;
    logic [DBD_LCNT_W-1:0]  lcnt_q, lcnt_d;
    logic                   vduty_q, vduty_d, ou_q, ou_d, alg_q, alg_d, err_q, err_d;

    logic vs_rise, de_fall, in_active, word_ok, line_end, frame_done, cnt_clr;

    assign vs_rise    = iVSYNC & ~vsync_q;
    assign de_fall    = ~iDE & de_q;
    assign in_active  = (state_q == ST_ACTIVE);
    assign word_ok    = in_active & iDE & ~line_full;
    assign line_end   = in_active & de_fall;
    assign frame_done = line_end & last_line & last_vblk;
    // Clearing on the rise itself makes FRAME_START already show address/count 0
    assign cnt_clr    = vs_rise | (state_q == ST_FRAME_START);

    dbd_block_pos_counter #(
        .H_BLOCKS       (H_BLOCKS),
        .WORDS_PER_HBLK (WORDS_PER_HBLK),
        .V_BLOCKS       (V_BLOCKS),
        .LINES_PER_VBLK (LINES_PER_VBLK)
    ) u_pos (
        .clk_i       (iODCK),
        .rst_ni      (iRST_n),
        .clr_i       (cnt_clr),
        .word_i      (in_active & iDE),
        .line_end_i  (line_end),
        .hblk_o      (hblk),
        .line_o      (line),
        .vblk_o      (vblk),
        .line_full_o (line_full),
        .last_line_o (last_line),
        .last_vblk_o (last_vblk)
    );

    // State and sync/enable history registers
    always_ff @(posedge iODCK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= ST_IDLE;
            vsync_q <= 1'b0;
            de_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_q <= iVSYNC;
            de_q    <= iDE;
        end
    end

    // Next state: a VSYNC rise always restarts the frame, even mid-frame
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:        if (vs_rise) state_d = ST_FRAME_START;
            ST_FRAME_START: state_d = ST_ACTIVE;
            ST_ACTIVE: begin
                if (vs_rise)         state_d = ST_FRAME_START;
                else if (frame_done) state_d = ST_FRAME_END;
            end
            ST_FRAME_END:   if (vs_rise) state_d = ST_FRAME_START;
            default:        state_d = ST_IDLE;
        endcase
    end

    // Output decode from the pre-update position, so a block-complete pulse still shows the finished block
    always_comb begin
        pix_d    = iPixelData;
        h_duty_d = word_ok ? (H_BLOCKS'(1) << hblk) : '0;
        vduty_d  = word_ok;
        ou_d     = line_end & last_line;
        alg_d    = (state_q == ST_FRAME_START);
        vaddr_d  = vblk;
        lcnt_d   = line;
        if (state_q == ST_FRAME_START) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q
                  | (in_active & iDE & line_full)
                  | (line_end & ~line_full)
                  | (in_active & vs_rise & ~frame_done)
                  | ((state_q == ST_FRAME_END) & iDE);
        end
    end

    // Output registers
    always_ff @(posedge iODCK or negedge iRST_n) begin
        if (!iRST_n) begin
            h_duty_q <= '0;
            pix_q    <= '0;
            vaddr_q  <= '0;
            lcnt_q   <= '0;
            vduty_q  <= 1'b0;
            ou_q     <= 1'b0;
            alg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            h_duty_q <= h_duty_d;
            pix_q    <= pix_d;
            vaddr_q  <= vaddr_d;
            lcnt_q   <= lcnt_d;
            vduty_q  <= vduty_d;
            ou_q     <= ou_d;
            alg_q    <= alg_d;
            err_q    <= err_d;
        end
    end

    assign oH_Duty             = h_duty_q;
    assign oPixelData          = pix_q;
    assign oV_Address          = vaddr_q;
    assign oV_Block_Duty_Count = lcnt_q;
    assign oV_Duty             = vduty_q;
    assign oOU_en              = ou_q;
    assign oALG_rst            = alg_q;
    assign oFrameErr           = err_q;

endmodule

// File: doc/dbd_block_timing_ctrl.md
Name: dbd_block_timing_ctrl

Overview:
Generates block-position sequencing for the dynamic backlight dimming input stage from raw frame timing (VSYNC, DE) and an 8-pixel-wide data bus. Produces a one-hot horizontal block select, vertical block address, line-in-block count, per-line valid, end-of-block enable and per-frame algorithm reset. The pixel word is re-registered so it stays cycle-aligned with the control outputs. Output feeds the input pipeline register stage ahead of the block accumulators.

Parameters:
H_BLOCKS, 24, horizontal blocks per line; width of oH_Duty (max 24)
WORDS_PER_HBLK, 10, 8-pixel words per horizontal block (1920 px line)
V_BLOCKS, 12, vertical blocks per frame (max 16)
LINES_PER_VBLK, 90, lines per vertical block (max 127)

Ports:
iODCK  in  1  pixel-word clock
iRST_n  in  1  reset, asynchronous, active-low
iVSYNC  in  1  frame sync, level; rising edge starts a frame
iDE  in  1  data enable, high during active words of a line
iPixelData  in  192  8 pixels x 24-bit RGB
oH_Duty  out  24  one-hot current horizontal block, zero when not active
oPixelData  out  192  iPixelData delayed 1 cycle
oV_Address  out  4  current vertical block index
oV_Duty  out  1  current word is valid and inside the active frame
oOU_en  out  1  one-cycle pulse: vertical block complete
oALG_rst  out  1  one-cycle pulse: clear accumulators for new frame
oV_Block_Duty_Count  out  7  line index within current vertical block
oFrameErr  out  1  sticky timing error, cleared at next frame start

Behaviour:
- One clock (iODCK). Reset: asynchronous, active-low (iRST_n). Reset clears every output and counter to 0; state = IDLE.
- All outputs registered. Latency 1: values describing the word sampled at edge N are valid after edge N; oPixelData follows the same rule in every state.
- VSYNC rise = iVSYNC high and previous sample low (internal 1-bit history register, reset 0).
- FSM states: IDLE, FRAME_START, ACTIVE, FRAME_END.
  - IDLE: DE ignored (oV_Duty=0, oH_Duty=0). VSYNC rise -> FRAME_START.
  - FRAME_START: one cycle. oALG_rst=1, counters cleared, oFrameErr cleared -> ACTIVE.
  - ACTIVE: while iDE=1: oV_Duty=1; oH_Duty = 1 << hblk; word counter increments, wraps at WORDS_PER_HBLK-1 and hblk increments. While iDE=0: oV_Duty=0, oH_Duty=0.
  - DE falling edge in ACTIVE: word/hblk counters clear; line counter increments. If line = LINES_PER_VBLK-1: oOU_en=1 for one cycle with oV_Address and oV_Block_Duty_Count still holding the completed block, then line=0 and oV_Address increments. If that block was V_BLOCKS-1 -> FRAME_END.
  - FRAME_END: DE ignored; VSYNC rise -> FRAME_START.
- Boundaries:
  - Words beyond H_BLOCKS*WORDS_PER_HBLK in a line: counters saturate, oH_Duty=0, oV_Duty=0, oFrameErr=1.
  - Line shorter than full width: accepted, oFrameErr=1.
  - DE during FRAME_END: ignored, oFrameErr=1.
  - VSYNC rise in ACTIVE: partial block discarded (no oOU_en), oFrameErr=1, -> FRAME_START.
  - VSYNC rise in the same cycle as the final DE fall of the frame: oOU_en issued that cycle; FRAME_START (oALG_rst) follows in the next cycle.
  - oOU_en and oALG_rst are never high in the same cycle.
  - Reset mid-frame: immediate clear; resume only after the next VSYNC rise.

Decomposition:
- Package dbd_pkg: FSM state enumeration; default geometry constants (24, 10, 12, 90); bus widths (192, 24, 4, 7).
- Sub-module dbd_block_pos_counter: nested word/hblk/line/vblk counters with wrap and saturate flags. The FSM and output registers stay in the top module.

Test Plan:
- Reset release, no VSYNC, DE toggling -> all outputs 0; oPixelData tracks input with 1-cycle delay.
- VSYNC rise -> oALG_rst high exactly 1 cycle; first DE word -> oH_Duty=24'h000001, oV_Address=0, oV_Duty=1; word 10 -> oH_Duty=24'h000002; word 239 -> 24'h800000.
- Full line 90 DE fall -> oOU_en 1 cycle with oV_Address=0 and count=89; next line shows oV_Address=1, count=0.
- Full frame of 1080 lines -> 12 oOU_en pulses; further DE ignored and oFrameErr=1; next VSYNC clears oFrameErr.
- VSYNC at line 45 of block 3 -> no oOU_en; oALG_rst pulse; oV_Address=0; oFrameErr=1. Line of 250 words -> words 240-249 give oH_Duty=0 and oFrameErr=1.
- iRST_n asserted mid-line -> outputs 0 immediately; DE ignored until the next VSYNC rise.
